// File: rtl/aib_flit_pkg.sv
// Flit format shared by the AIB Tx framer and, later, the Rx deframer.
// Holds the flit type encoding, field positions, the flit struct and its builder.
package aib_flit_pkg;

  typedef enum logic [1:0] {
    FT_HEAD = 2'd1,
    FT_DATA = 2'd2,
    FT_TAIL = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } framer_state_e;

  localparam int FLIT_W    = 72;
  localparam int PAYLOAD_W = 64;
  localparam int TYPE_HI   = 71;
  localparam int TYPE_LO   = 70;
  localparam int DEST_HI   = 69;
  localparam int DEST_LO   = 66;
  localparam int SEQ_HI    = 65;
  localparam int SEQ_LO    = 64;

  typedef struct packed {
    flit_type_e           ftype;
    logic [3:0]           dest;
    logic [1:0]           seq;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  function automatic flit_t mk_flit(input flit_type_e ftype, input logic [3:0] dest,
                                    input logic [1:0] seq, input logic [PAYLOAD_W-1:0] payload);
    logic [FLIT_W-1:0] f;
    f                        = '0;
    f[TYPE_HI:TYPE_LO]       = ftype;
    f[DEST_HI:DEST_LO]       = dest;
    f[SEQ_HI:SEQ_LO]         = seq;
    f[PAYLOAD_W-1:0]         = payload;
    return flit_t'(f);
  endfunction

endpackage

// File: rtl/aib_tx_slot.sv
// Single-entry valid/ready output register: loads only when empty or draining,
// and holds valid/data stable while the consumer stalls.
module aib_tx_slot #(
  parameter int W = 72
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_slot_free,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         slot_free;

  assign slot_free   = !valid_q | i_ready;
  assign o_slot_free = slot_free;
  assign o_valid     = valid_q;
  assign o_data      = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (slot_free) begin
      valid_d = i_load;
      if (i_load) data_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/aib_tx_framer.sv
// Link-layer framer: wraps fabric messages as HEAD/DATA.../TAIL flits toward the AIB
// channel, truncating messages longer than MAX_BEATS and discarding their remainder.
module aib_tx_framer
  import aib_flit_pkg::*;
#(
  parameter int MAX_BEATS = 255,
  parameter int SEQ_W     = 16
) (
  input  logic             i_bus_clk,
  input  logic             i_rst,
  input  logic             i_msg_valid,
  output logic             o_msg_ready,
  input  logic [63:0]      i_msg_data,
  input  logic             i_msg_last,
  input  logic [3:0]       i_msg_dest,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [71:0]      o_tx_data,
  output logic             o_err_overlen,
  output logic [SEQ_W-1:0] o_pkt_seq
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

  framer_state_e    state_q, state_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [3:0]       dest_q, dest_d;
  logic [SEQ_W-1:0] pkt_seq_q, pkt_seq_d;
  logic             err_q, err_d;

  logic  slot_free;
  logic  load;
  logic  accept;
  flit_t flit;

  assign o_msg_ready   = ((state_q == ST_DATA) & slot_free) | (state_q == ST_DROP);
  assign accept        = i_msg_valid & o_msg_ready;
  assign o_err_overlen = err_q;
  assign o_pkt_seq     = pkt_seq_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    dest_d     = dest_q;
    pkt_seq_d  = pkt_seq_q;
    err_d      = 1'b0;
    load       = 1'b0;
    flit       = '0;
    case (state_q)
      ST_IDLE: begin
        // HEAD goes out as soon as a message is pending; its first beat waits for DATA.
        if (i_msg_valid & slot_free) begin
          load       = 1'b1;
          flit       = mk_flit(FT_HEAD, i_msg_dest, pkt_seq_q[1:0], 64'(pkt_seq_q));
          dest_d     = i_msg_dest;
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          load       = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (i_msg_last) begin
            flit      = mk_flit(FT_TAIL, dest_q, pkt_seq_q[1:0], i_msg_data);
            pkt_seq_d = pkt_seq_q + SEQ_W'(1);
            state_d   = ST_IDLE;
          end else if (beat_cnt_q == LAST_CNT) begin
            // Limit reached without last: close the packet here and swallow the rest.
            flit      = mk_flit(FT_TAIL, dest_q, pkt_seq_q[1:0], i_msg_data);
            pkt_seq_d = pkt_seq_q + SEQ_W'(1);
            err_d     = 1'b1;
            state_d   = ST_DROP;
          end else begin
            flit = mk_flit(FT_DATA, dest_q, pkt_seq_q[1:0], i_msg_data);
          end
        end
      end
      ST_DROP: begin
        if (accept & i_msg_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_bus_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      dest_q     <= '0;
      pkt_seq_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      dest_q     <= dest_d;
      pkt_seq_q  <= pkt_seq_d;
      err_q      <= err_d;
    end
  end

  aib_tx_slot #(
    .W(FLIT_W)
  ) u_slot (
    .i_clk       (i_bus_clk),
    .i_rst       (i_rst),
    .i_load      (load),
    .i_data      (flit),
    .o_slot_free (slot_free),
    .o_valid     (o_tx_valid),
    .i_ready     (i_tx_ready),
    .o_data      (o_tx_data)
  );

endmodule

// File: tb/tb_aib_tx_framer.sv
// Self-checking bench for aib_tx_framer: random messages and channel stalls checked
// against a message-level flit model (small MAX_BEATS/SEQ_W keep runs short).
module tb_aib_tx_framer;

  localparam int MAXB    = 4;
  localparam int SEQ_W   = 4;
  localparam int SEQ_MOD = 1 << SEQ_W;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_msg_valid = 1'b0;
  logic             o_msg_ready;
  logic [63:0]      i_msg_data = '0;
  logic             i_msg_last = 1'b0;
  logic [3:0]       i_msg_dest = '0;
  logic             o_tx_valid;
  logic             i_tx_ready = 1'b1;
  logic [71:0]      o_tx_data;
  logic             o_err_overlen;
  logic [SEQ_W-1:0] o_pkt_seq;

  int total = 0;
  int bad   = 0;

  logic [71:0] got_q[$];
  logic [71:0] exp_q[$];
  int          model_seq = 0;
  int          exp_err   = 0;
  int          err_cnt   = 0;
  int          stab_err  = 0;

  always #5 clk = ~clk;

  aib_tx_framer #(.MAX_BEATS(MAXB), .SEQ_W(SEQ_W)) dut (
    .i_bus_clk     (clk),
    .i_rst         (i_rst),
    .i_msg_valid   (i_msg_valid),
    .o_msg_ready   (o_msg_ready),
    .i_msg_data    (i_msg_data),
    .i_msg_last    (i_msg_last),
    .i_msg_dest    (i_msg_dest),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_tx_data     (o_tx_data),
    .o_err_overlen (o_err_overlen),
    .o_pkt_seq     (o_pkt_seq)
  );

  // Channel-side monitor: collects delivered flits, error pulses and stall stability.
  initial begin
    logic        prev_stall;
    logic [71:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stab_err++;
        if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
        if (o_err_overlen) err_cnt++;
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
      end
    end
  end

  // Expected flits for one message, from the framing rules alone.
  task automatic model_msg(input logic [3:0] dest, input logic [63:0] beats[$]);
    exp_q.push_back({2'b01, dest, 2'(model_seq), 64'(model_seq)});
    for (int i = 0; i < beats.size(); i++) begin
      if (i == beats.size() - 1 || i == MAXB - 1) begin
        exp_q.push_back({2'b11, dest, 2'(model_seq), beats[i]});
        if (i != beats.size() - 1) exp_err++;
        model_seq = (model_seq + 1) % SEQ_MOD;
        break;
      end
      exp_q.push_back({2'b10, dest, 2'(model_seq), beats[i]});
    end
  endtask

  // Drives one message beat by beat; called and returns just after a rising edge.
  task automatic send_msg(input logic [3:0] dest, input int n, input int gap_pct);
    logic [63:0] beats[$];
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    model_msg(dest, beats);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        i_msg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      i_msg_valid = 1'b1;
      i_msg_data  = beats[i];
      i_msg_last  = (i == n - 1);
      i_msg_dest  = (i == 0) ? dest : 4'($urandom);
      begin
        int t;
        for (t = 0; t < 200; t++) begin
          @(negedge clk);
          if (o_msg_ready) break;
        end
        total++;
        if (t == 200) begin
          bad++;
          $display("FAIL beat_accept_timeout: beat %0d of %0d never accepted, ready=%b", i, n, o_msg_ready);
        end
      end
      @(posedge clk);
      #1;
    end
    i_msg_valid = 1'b0;
    i_msg_last  = 1'b0;
    i_msg_dest  = 4'($urandom);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size() && !o_tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b need 0", o_tx_valid); end
    total++; if (o_tx_data !== 72'h0) begin bad++; $display("FAIL reset_tx_data: got %h need 0", o_tx_data); end
    total++; if (o_msg_ready !== 1'b0) begin bad++; $display("FAIL reset_msg_ready: got %b need 0", o_msg_ready); end
    total++; if (o_err_overlen !== 1'b0) begin bad++; $display("FAIL reset_err: got %b need 0", o_err_overlen); end
    total++; if (o_pkt_seq !== '0) begin bad++; $display("FAIL reset_pkt_seq: got %0d need 0", o_pkt_seq); end
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_one_beat;
    logic [63:0] d;
    logic [71:0] head, tail;
    d    = {$urandom, $urandom};
    head = {2'b01, 4'h5, 2'b00, 64'h0};
    tail = {2'b11, 4'h5, 2'b00, d};
    i_tx_ready  = 1'b1;
    i_msg_valid = 1'b1;
    i_msg_data  = d;
    i_msg_last  = 1'b1;
    i_msg_dest  = 4'h5;
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b0 || o_msg_ready !== 1'b0) begin bad++; $display("FAIL one_beat_idle: valid=%b ready=%b need 0 0", o_tx_valid, o_msg_ready); end
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b1 || o_tx_data !== head) begin bad++; $display("FAIL one_beat_head: valid=%b data=%h need 1 %h", o_tx_valid, o_tx_data, head); end
    total++; if (o_msg_ready !== 1'b1) begin bad++; $display("FAIL one_beat_ready: got %b need 1", o_msg_ready); end
    @(posedge clk);
    #1;
    i_msg_valid = 1'b0;
    i_msg_last  = 1'b0;
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b1 || o_tx_data !== tail) begin bad++; $display("FAIL one_beat_tail: valid=%b data=%h need 1 %h", o_tx_valid, o_tx_data, tail); end
    total++; if (o_pkt_seq !== SEQ_W'(1)) begin bad++; $display("FAIL one_beat_seq: got %0d need 1", o_pkt_seq); end
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL one_beat_idle_after: got %b need 0", o_tx_valid); end
    @(posedge clk);
    #1;
    model_seq = 1;
    got_q.delete();
    $display("test_one_beat done: head=%h tail=%h", head, tail);
  endtask

  task automatic test_stall;
    bit ok;
    i_tx_ready = 1'b1;
    fork
      send_msg(4'hA, 4, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        i_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_tx_ready = 1'b1;
      end
    join
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count: got %0d flits need %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL stall_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL stall_stable: %0d unstable cycles need 0", stab_err); end
    $display("test_stall done: %0d flits", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overlen;
    bit ok;
    int err0;
    err0 = err_cnt;
    i_tx_ready = 1'b1;
    send_msg(4'h3, 7, 0);
    send_msg(4'hC, 1, 0);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != 7) begin bad++; $display("FAIL overlen_count: got %0d flits need 7", got_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL overlen_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    total++; if (err_cnt - err0 != 1) begin bad++; $display("FAIL overlen_err_pulse: got %0d cycles need 1", err_cnt - err0); end
    total++; if (o_pkt_seq !== SEQ_W'(model_seq)) begin bad++; $display("FAIL overlen_seq: got %0d need %0d", o_pkt_seq, model_seq); end
    $display("test_overlen done: seq=%0d", o_pkt_seq);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_exact_max;
    bit ok;
    int err0;
    err0 = err_cnt;
    i_tx_ready = 1'b1;
    send_msg(4'h7, MAXB, 0);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != MAXB + 1) begin bad++; $display("FAIL exact_count: got %0d flits need %0d", got_q.size(), MAXB + 1); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL exact_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    total++; if (err_cnt != err0) begin bad++; $display("FAIL exact_no_err: got %0d pulses need 0", err_cnt - err0); end
    $display("test_exact_max done");
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    i_tx_ready  = 1'b1;
    i_msg_dest  = 4'h9;
    i_msg_last  = 1'b0;
    i_msg_valid = 1'b1;
    i_msg_data  = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    i_msg_valid = 1'b0;
    i_rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (o_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b need 0", o_tx_valid); end
    total++; if (o_pkt_seq !== '0) begin bad++; $display("FAIL rst_mid_seq: got %0d need 0", o_pkt_seq); end
    @(posedge clk);
    #1;
    i_rst     = 1'b0;
    model_seq = 0;
    got_q.delete(); exp_q.delete();
    send_msg(4'h2, 1, 0);
    wait_drain(ok);
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL rst_mid_count: got %0d flits need 2", got_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rst_mid_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    $display("test_reset_mid done");
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    bit ok;
    bit done;
    int err0;
    err0 = err_cnt;
    done = 1'b0;
    fork
      begin
        for (int m = 0; m < 25; m++) send_msg(4'($urandom), $urandom_range(1, 7), 25);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          i_tx_ready = ($urandom_range(0, 3) != 0);
        end
        i_tx_ready = 1'b1;
      end
    join
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count: got %0d flits need %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL random_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    total++; if (err_cnt - err0 != exp_err) begin bad++; $display("FAIL random_err: got %0d pulses need %0d", err_cnt - err0, exp_err); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL random_stable: %0d unstable cycles need 0", stab_err); end
    $display("test_random done: %0d flits, %0d truncations", got_q.size(), exp_err);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap;
    bit ok;
    bit wrapped;
    wrapped = 1'b0;
    i_tx_ready = 1'b1;
    for (int m = 0; m < SEQ_MOD + 1; m++) begin
      send_msg(4'($urandom), 1, 0);
      if (model_seq == 0) wrapped = 1'b1;
      total++;
      if (o_pkt_seq !== SEQ_W'(model_seq)) begin bad++; $display("FAIL wrap_seq[%0d]: got %0d need %0d", m, o_pkt_seq, model_seq); end
    end
    wait_drain(ok);
    total++; if (!ok || got_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d flits need %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin bad++; $display("FAIL wrap_flit[%0d]: got %h need %h", k, got_q[k], exp_q[k]); end
    end
    $display("test_wrap done: wrapped=%0d seq=%0d", wrapped, o_pkt_seq);
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_one_beat();
    test_stall();
    exp_err = 0;
    test_overlen();
    test_exact_max();
    test_reset_mid();
    exp_err = 0;
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
